// File: rtl/aes_tb_pkg.sv
// Shared AES bench types: block width, core latency, block type and the MISR fold step.
package aes_tb_pkg;

  localparam int AES_BLOCK_W       = 128;
  localparam int AES_CYCLE_LATENCY = 21;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  // Rotate-left-by-one then XOR in the new block.
  function automatic aes_block_t misr_next(input aes_block_t sig, input aes_block_t data);
    return {sig[AES_BLOCK_W-2:0], sig[AES_BLOCK_W-1]} ^ data;
  endfunction

endpackage

// File: rtl/aes_ct_fifo.sv
// Sync FIFO for captured ciphertext; head is zero while empty. Latency 1 cycle push->head.
// No internal guard: caller only pushes when not full or when popping in the same cycle.
module aes_ct_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Extra pointer MSB separates full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_dat;
        wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/aes_ct_collector.sv
// Tracks aes_128 valids through a latency-matched pipe and captures ciphertext into a ready/valid FIFO;
// 1 cycle tap->out_valid, drops on full with sticky overflow. MISR signature only with AES_CT_COLLECTOR_MISR_EN.
module aes_ct_collector
  import aes_tb_pkg::*;
#(
  parameter int LATENCY    = AES_CYCLE_LATENCY,
  parameter int DATA_W     = AES_BLOCK_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] ct_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       ct_count,
  output logic [DATA_W-1:0] signature,
  output logic              overflow
);

  logic [LATENCY-1:0] vpipe_q, vpipe_d;
  logic [31:0]        ct_count_q, ct_count_d;
  logic               overflow_q, overflow_d;
  logic               tap, pop, push_acc, drop;
  logic               fifo_full, fifo_empty;

  assign tap       = vpipe_q[LATENCY-1];
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready && !clear;
  // A full FIFO still takes the new block when the head leaves in the same cycle.
  assign push_acc  = tap && !clear && (!fifo_full || pop);
  assign drop      = tap && !clear && !push_acc;

  always_comb begin
    vpipe_d    = (vpipe_q << 1) | LATENCY'(in_valid);
    ct_count_d = ct_count_q + 32'(push_acc);
    overflow_d = overflow_q | drop;
    if (clear) begin
      vpipe_d    = '0;
      ct_count_d = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q    <= '0;
      ct_count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      vpipe_q    <= vpipe_d;
      ct_count_q <= ct_count_d;
      overflow_q <= overflow_d;
    end
  end

  assign ct_count = ct_count_q;
  assign overflow = overflow_q;

  aes_ct_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (push_acc),
    .push_dat (ct_in),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (out_data)
  );

`ifdef AES_CT_COLLECTOR_MISR_EN
  logic [DATA_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (push_acc) begin
      sig_d = misr_next(sig_q, ct_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_aes_ct_collector.sv
// Directed bench for aes_ct_collector: latency, back-to-back, overflow, full+pop, clear and async reset.
module tb_aes_ct_collector;
  import aes_tb_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n, clear, in_valid, out_ready;
  logic [127:0] ct_in;
  logic         out_valid, overflow;
  logic [127:0] out_data, signature;
  logic [31:0]  ct_count;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc   = 0;
  int           c;
  logic         seen;
  logic [127:0] msig;

  always #5 clk = ~clk;

  aes_ct_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .ct_in     (ct_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ct_count  (ct_count),
    .signature (signature),
    .overflow  (overflow)
  );

  // Ciphertext presented during cycle k.
  function automatic logic [127:0] mk(input int k);
    logic [31:0] u;
    u = 32'(k);
    return {u ^ 32'hA5A5_0000, ~u, u * 32'd3, u + 32'h1357_9BDF};
  endfunction

  function automatic logic [127:0] mis(input logic [127:0] s, input logic [127:0] d);
    return {s[126:0], s[127]} ^ d;
  endfunction

  function automatic logic [127:0] exp_sig(input logic [127:0] m);
`ifdef AES_CT_COLLECTOR_MISR_EN
    return m;
`else
    return '0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    ct_in = mk(cyc);
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) step();
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ct_in = mk(0);
    msig = '0;
    step(); step();
    chk1 ("rst_vld", out_valid, 1'b0);
    chk  ("rst_dat", out_data, '0);
    chk32("rst_cnt", ct_count, 32'd0);
    chk  ("rst_sig", signature, '0);
    chk1 ("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;

    // Single valid in cycle 5 -> out_valid in cycle 27 with cycle-26 data.
    wait_until(5); in_valid = 1'b1; step(); in_valid = 1'b0;
    wait_until(26);
    chk1("t1_pre", out_valid, 1'b0);
    step();
    chk1 ("t1_vld", out_valid, 1'b1);
    chk  ("t1_dat", out_data, mk(26));
    chk32("t1_cnt", ct_count, 32'd1);
    msig = mis('0, mk(26));
    chk  ("t1_sig", signature, exp_sig(msig));
    out_ready = 1'b1; step();
    chk1("t1_pop", out_valid, 1'b0);

    // Back-to-back: 10 valids, consumer always ready.
    clear = 1'b1; step(); clear = 1'b0; msig = '0;
    chk32("t2_clr", ct_count, 32'd0);
    c = cyc; in_valid = 1'b1; repeat (10) step(); in_valid = 1'b0;
    wait_until(c + 22);
    for (int i = 0; i < 10; i++) begin
      chk1("t2_vld", out_valid, 1'b1);
      chk ("t2_dat", out_data, mk(c + 21 + i));
      msig = mis(msig, mk(c + 21 + i));
      step();
    end
    chk1 ("t2_end", out_valid, 1'b0);
    chk32("t2_cnt", ct_count, 32'd10);
    chk  ("t2_sig", signature, exp_sig(msig));

    // Backpressure: 6 valids into a 4-deep FIFO with no consumer.
    clear = 1'b1; out_ready = 1'b0; step(); clear = 1'b0; msig = '0;
    c = cyc; in_valid = 1'b1; repeat (6) step(); in_valid = 1'b0;
    wait_until(c + 25);
    chk1 ("t3_ovf_pre", overflow, 1'b0);
    chk32("t3_cnt_pre", ct_count, 32'd4);
    wait_until(c + 27);
    chk1 ("t3_ovf", overflow, 1'b1);
    chk32("t3_cnt", ct_count, 32'd4);
    for (int i = 0; i < 4; i++) msig = mis(msig, mk(c + 21 + i));
    chk  ("t3_sig", signature, exp_sig(msig));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk1("t3_vld", out_valid, 1'b1);
      chk ("t3_dat", out_data, mk(c + 21 + i));
      step();
    end
    chk1("t3_end", out_valid, 1'b0);
    chk1("t3_ovf_stk", overflow, 1'b1);

    // Full FIFO with a pop in the same cycle as a new tap.
    clear = 1'b1; out_ready = 1'b0; step(); clear = 1'b0;
    chk1("t4_clr_ovf", overflow, 1'b0);
    c = cyc; in_valid = 1'b1; repeat (5) step(); in_valid = 1'b0;
    wait_until(c + 25);
    chk("t4_full_head", out_data, mk(c + 21));
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk1 ("t4_ovf", overflow, 1'b0);
    chk32("t4_cnt", ct_count, 32'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk1("t4_vld", out_valid, 1'b1);
      chk ("t4_dat", out_data, mk(c + 22 + i));
      step();
    end
    chk1("t4_end", out_valid, 1'b0);

    // Clear while three valids are in flight.
    chk32("t5_cnt_pre", ct_count, 32'd5);
    c = cyc; in_valid = 1'b1; repeat (3) step(); in_valid = 1'b0;
    wait_until(c + 5); clear = 1'b1; step(); clear = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk1 ("t5_seen", seen, 1'b0);
    chk32("t5_cnt", ct_count, 32'd0);
    chk  ("t5_sig", signature, '0);
    chk1 ("t5_ovf", overflow, 1'b0);

    // Async reset between edges with two entries held.
    out_ready = 1'b0;
    c = cyc; in_valid = 1'b1; repeat (2) step(); in_valid = 1'b0;
    wait_until(c + 23);
    chk1 ("t6_vld_pre", out_valid, 1'b1);
    chk32("t6_cnt_pre", ct_count, 32'd2);
    msig = mis(mis('0, mk(c + 21)), mk(c + 22));
    chk  ("t6_sig_pre", signature, exp_sig(msig));
    #2 rst_n = 1'b0;
    #1;
    chk1 ("t6_vld", out_valid, 1'b0);
    chk32("t6_cnt", ct_count, 32'd0);
    chk  ("t6_sig", signature, '0);
    chk  ("t6_dat", out_data, '0);
    #1 rst_n = 1'b1;
    repeat (25) step();
    chk1("t6_quiet", out_valid, 1'b0);
    c = cyc; in_valid = 1'b1; step(); in_valid = 1'b0;
    wait_until(c + 22);
    chk1 ("t6_re_vld", out_valid, 1'b1);
    chk  ("t6_re_dat", out_data, mk(c + 21));
    chk32("t6_re_cnt", ct_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
